// File: rtl/cpu_cycle_ctrl_if.sv
// Handshake/bus bundle between the instruction sequencer and the datapath/memory side.
// The master modport is the sequencer; the slave modport is the datapath it controls.
interface cpu_cycle_ctrl_if;
    logic        run;
    logic        exec_ok;
    logic        is_branch;
    logic        is_link;
    logic        is_mem;
    logic        is_load;
    logic        no_wb;
    logic        wr_pc;
    logic [31:0] br_target;
    logic [31:0] wb_data;
    logic        mem_ack;

    logic [31:0] pc;
    logic        ifetch_en;
    logic        rf_read_en;
    logic        alu_en;
    logic        mem_req;
    logic        rf_write_en;
    logic        link_we;
    logic [2:0]  state;
    logic [15:0] instr_count;
    logic        err;

    modport master (
        input  run, exec_ok, is_branch, is_link, is_mem, is_load, no_wb, wr_pc,
        input  br_target, wb_data, mem_ack,
        output pc, ifetch_en, rf_read_en, alu_en, mem_req, rf_write_en, link_we,
        output state, instr_count, err
    );

    modport slave (
        output run, exec_ok, is_branch, is_link, is_mem, is_load, no_wb, wr_pc,
        output br_target, wb_data, mem_ack,
        input  pc, ifetch_en, rf_read_en, alu_en, mem_req, rf_write_en, link_we,
        input  state, instr_count, err
    );
endinterface

// File: rtl/cpu_cycle_ctrl.sv
// Multi-cycle instruction sequencer: walks FETCH/READ/EXEC/MEM/WB, owns the PC,
// counts retired instructions and latches a sticky error on memory timeout.
module cpu_cycle_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input logic              clk,
    input logic              nreset,
    cpu_cycle_ctrl_if.master bus
);

    localparam int unsigned     CntW    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFetch = 3'd1,
        StRead  = 3'd2,
        StExec  = 3'd3,
        StMem   = 3'd4,
        StWb    = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [CntW-1:0] wait_q, wait_d;

    logic            retire;
    logic [31:0]     pc_inc;
    state_e          next_st;

    assign pc_inc  = pc_q + 32'd4;
    assign next_st = bus.run ? StFetch : StIdle;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        wait_d  = wait_q;
        retire  = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.run && !err_q) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = StRead;
            end
            StRead: begin
                if (bus.exec_ok) begin
                    state_d = StExec;
                end else begin
                    // Condition failed: skip without retiring.
                    pc_d    = pc_inc;
                    state_d = next_st;
                end
            end
            StExec: begin
                if (bus.is_branch) begin
                    pc_d    = bus.br_target;
                    retire  = 1'b1;
                    state_d = next_st;
                end else if (bus.is_mem) begin
                    wait_d  = '0;
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                // An ack on the last allowed cycle still completes the access.
                if (bus.mem_ack) begin
                    if (bus.is_load) begin
                        state_d = StWb;
                    end else begin
                        pc_d    = pc_inc;
                        retire  = 1'b1;
                        state_d = next_st;
                    end
                end else if (wait_q == CntLast) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    wait_d = wait_q + CntW'(1);
                end
            end
            StWb: begin
                if (!bus.no_wb && bus.wr_pc) begin
                    pc_d = bus.wb_data;
                end else begin
                    pc_d = pc_inc;
                end
                retire  = 1'b1;
                state_d = next_st;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (retire) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            cnt_q   <= 16'd0;
            err_q   <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.state       = state_q;
    assign bus.instr_count = cnt_q;
    assign bus.err         = err_q;

    assign bus.ifetch_en   = (state_q == StFetch);
    assign bus.rf_read_en  = (state_q == StRead);
    assign bus.alu_en      = (state_q == StExec);
    assign bus.mem_req     = (state_q == StMem);
    assign bus.link_we     = (state_q == StExec) && bus.is_branch && bus.is_link;
    assign bus.rf_write_en = (state_q == StWb) && !bus.no_wb && !bus.wr_pc;

    a_enables_onehot: assert property (@(posedge clk) disable iff (!nreset)
        $onehot0({bus.ifetch_en, bus.rf_read_en, bus.alu_en, bus.mem_req, bus.rf_write_en}));

    a_err_idle: assert property (@(posedge clk) disable iff (!nreset)
        err_q |-> (state_q == StIdle));

endmodule

// File: tb/tb_cpu_cycle_ctrl.sv
// Self-checking bench for cpu_cycle_ctrl: a table of instructions run back to back with a
// scoreboard of expected per-instruction results, plus hand sequences for reset/timeout/run.
module tb_cpu_cycle_ctrl;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    cpu_cycle_ctrl_if bus ();

    cpu_cycle_ctrl #(
        .RESET_PC   (32'h0000_0000),
        .MEM_TIMEOUT(16)
    ) dut (
        .clk   (clk),
        .nreset(nreset),
        .bus   (bus)
    );

    typedef struct {
        int          cycles;
        int          wr;
        int          link;
        int          alu;
        int          mem;
        logic [31:0] pc;
        logic [15:0] cnt;
        logic        idle;
    } exp_t;

    typedef struct {
        logic [7:0]  flags;  // {run, exec_ok, is_branch, is_link, is_mem, is_load, no_wb, wr_pc}
        logic [31:0] br;
        logic [31:0] wb;
        int          ack_at; // MEM cycle (1-based) on which mem_ack is raised; 0 = never
        logic [31:0] pc_fetch;
        exp_t        exp;
    } vec_t;

    int errors = 0;
    int checks = 0;
    exp_t sb[$];
    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] flags, input logic [31:0] br,
                                input logic [31:0] wb, input int ack_at,
                                input logic [31:0] pcf, input int cyc, input int wr,
                                input int link, input int alu, input int mem,
                                input logic [31:0] pc, input logic [15:0] cnt,
                                input logic idle);
        vec_t v;
        v.flags = flags; v.br = br; v.wb = wb; v.ack_at = ack_at; v.pc_fetch = pcf;
        v.exp.cycles = cyc; v.exp.wr = wr; v.exp.link = link; v.exp.alu = alu;
        v.exp.mem = mem; v.exp.pc = pc; v.exp.cnt = cnt; v.exp.idle = idle;
        return v;
    endfunction

    task automatic set_decode(input logic [7:0] f, input logic [31:0] br, input logic [31:0] wb);
        bus.run       = f[7];
        bus.exec_ok   = f[6];
        bus.is_branch = f[5];
        bus.is_link   = f[4];
        bus.is_mem    = f[3];
        bus.is_load   = f[2];
        bus.no_wb     = f[1];
        bus.wr_pc     = f[0];
        bus.br_target = br;
        bus.wb_data   = wb;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called while the DUT sits in FETCH; runs one instruction to its next FETCH or IDLE.
    task automatic run_instr(input vec_t v, input int idx);
        exp_t e;
        int cyc, wr, link, alu, mem, mcnt;
        bit done;
        check($sformatf("v%0d_fetch_state", idx), 32'(bus.state), 32'd1);
        check($sformatf("v%0d_fetch_pc", idx), bus.pc, v.pc_fetch);
        set_decode(v.flags, v.br, v.wb);
        bus.mem_ack = 1'b0;
        sb.push_back(v.exp);
        cyc = 1; wr = 0; link = 0; alu = 0; mem = 0; mcnt = 0; done = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (bus.ifetch_en || bus.state == 3'd0) begin
                done = 1'b1;
                break;
            end
            cyc++;
            wr   += int'(bus.rf_write_en);
            link += int'(bus.link_we);
            alu  += int'(bus.alu_en);
            mem  += int'(bus.mem_req);
            if (bus.state == 3'd4) begin
                mcnt++;
                bus.mem_ack = (v.ack_at != 0) && (mcnt == v.ack_at);
            end else begin
                bus.mem_ack = 1'b0;
            end
        end
        bus.mem_ack = 1'b0;
        check($sformatf("v%0d_completed", idx), 32'(done), 32'd1);
        e = sb.pop_front();
        check($sformatf("v%0d_cycles", idx), cyc, e.cycles);
        check($sformatf("v%0d_wr_pulses", idx), wr, e.wr);
        check($sformatf("v%0d_link_pulses", idx), link, e.link);
        check($sformatf("v%0d_alu_cycles", idx), alu, e.alu);
        check($sformatf("v%0d_mem_cycles", idx), mem, e.mem);
        check($sformatf("v%0d_pc", idx), bus.pc, e.pc);
        check($sformatf("v%0d_count", idx), 32'(bus.instr_count), 32'(e.cnt));
        check($sformatf("v%0d_idle", idx), 32'(bus.state == 3'd0), 32'(e.idle));
        check($sformatf("v%0d_err", idx), 32'(bus.err), 32'd0);
    endtask

    initial begin
        int mcyc;
        bit seen;
        vecs[0]  = mk(8'b1100_0000, 32'h0, 32'hAAAA, 0, 32'h0,   4, 1, 0, 1, 0, 32'h4,   1, 0);
        vecs[1]  = mk(8'b1100_0000, 32'h0, 32'hBBBB, 0, 32'h4,   4, 1, 0, 1, 0, 32'h8,   2, 0);
        vecs[2]  = mk(8'b1100_0000, 32'h0, 32'hCCCC, 0, 32'h8,   4, 1, 0, 1, 0, 32'hC,   3, 0);
        vecs[3]  = mk(8'b1111_0000, 32'h40, 32'h0,   0, 32'hC,   3, 0, 1, 1, 0, 32'h40,  4, 0);
        vecs[4]  = mk(8'b1010_0000, 32'h80, 32'h0,   0, 32'h40,  2, 0, 0, 0, 0, 32'h44,  4, 0);
        vecs[5]  = mk(8'b1100_0010, 32'h0, 32'h0,    0, 32'h44,  4, 0, 0, 1, 0, 32'h48,  5, 0);
        vecs[6]  = mk(8'b1100_0001, 32'h0, 32'h100,  0, 32'h48,  4, 0, 0, 1, 0, 32'h100, 6, 0);
        vecs[7]  = mk(8'b1100_1100, 32'h0, 32'h55,   3, 32'h100, 7, 1, 0, 1, 3, 32'h104, 7, 0);
        vecs[8]  = mk(8'b1100_1101, 32'h0, 32'h200,  1, 32'h104, 5, 0, 0, 1, 1, 32'h200, 8, 0);
        vecs[9]  = mk(8'b1100_1000, 32'h0, 32'h0,    1, 32'h200, 4, 0, 0, 1, 1, 32'h204, 9, 0);
        vecs[10] = mk(8'b1100_1000, 32'h0, 32'h0,   16, 32'h204, 19, 0, 0, 1, 16, 32'h208, 10, 0);
        vecs[11] = mk(8'b1110_0000, 32'hFFFF_FFFC, 32'h0, 0, 32'h208, 3, 0, 0, 1, 0,
                      32'hFFFF_FFFC, 11, 0);
        vecs[12] = mk(8'b1100_0000, 32'h0, 32'h0,    0, 32'hFFFF_FFFC, 4, 1, 0, 1, 0, 32'h0, 12, 0);
        vecs[13] = mk(8'b0100_0000, 32'h0, 32'h0,    0, 32'h0,   4, 1, 0, 1, 0, 32'h4,  13, 1);

        set_decode(8'h00, 32'h0, 32'h0);
        bus.mem_ack = 1'b0;
        repeat (2) tick();
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_pc", bus.pc, 32'h0);
        check("rst_count", 32'(bus.instr_count), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_enables", {26'd0, bus.ifetch_en, bus.rf_read_en, bus.alu_en, bus.mem_req,
              bus.rf_write_en, bus.link_we}, 32'd0);
        nreset = 1'b1;
        tick();
        check("idle_without_run", 32'(bus.state), 32'd0);
        bus.run = 1'b1;
        tick();
        check("first_fetch", 32'(bus.ifetch_en), 32'd1);

        for (int i = 0; i < 14; i++) run_instr(vecs[i], i);

        tick();
        check("stay_idle_run0", 32'(bus.state), 32'd0);
        check("idle_pc_held", bus.pc, 32'h4);

        // Run drops while in EXEC: instruction finishes, then IDLE.
        bus.run = 1'b1;
        tick();
        check("seqA_fetch", 32'(bus.ifetch_en), 32'd1);
        set_decode(8'b1100_0000, 32'h0, 32'h0);
        tick();
        tick();
        check("seqA_exec", 32'(bus.alu_en), 32'd1);
        bus.run = 1'b0;
        tick();
        check("seqA_wb_write", 32'(bus.rf_write_en), 32'd1);
        tick();
        check("seqA_idle", 32'(bus.state), 32'd0);
        check("seqA_pc", bus.pc, 32'h8);
        check("seqA_count", 32'(bus.instr_count), 32'd14);

        // Store with no ack: timeout after 16 MEM cycles, sticky err.
        bus.run = 1'b1;
        tick();
        check("seqB_fetch_pc", bus.pc, 32'h8);
        set_decode(8'b1100_1000, 32'h0, 32'h0);
        mcyc = 0;
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (bus.mem_req) begin
                mcyc++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
        end
        check("seqB_mem_cycles", mcyc, 32'd16);
        check("seqB_err", 32'(bus.err), 32'd1);
        check("seqB_state", 32'(bus.state), 32'd0);
        check("seqB_pc_held", bus.pc, 32'h8);
        check("seqB_count", 32'(bus.instr_count), 32'd14);
        bus.mem_ack = 1'b1;
        repeat (3) tick();
        check("seqB_err_blocks_run", 32'(bus.state), 32'd0);
        bus.mem_ack = 1'b0;
        nreset = 1'b0;
        #1;
        check("seqB_reset_clears_err", 32'(bus.err), 32'd0);
        check("seqB_reset_pc", bus.pc, 32'h0);
        tick();
        nreset = 1'b1;
        tick();
        check("seqB_fetch_after_reset", 32'(bus.ifetch_en), 32'd1);

        // Reset asserted mid-MEM drops mem_req immediately.
        set_decode(8'b1100_1000, 32'h0, 32'h0);
        repeat (4) tick();
        check("seqC_in_mem", 32'(bus.mem_req), 32'd1);
        #2;
        nreset = 1'b0;
        #1;
        check("seqC_mem_req_drop", 32'(bus.mem_req), 32'd0);
        check("seqC_state", 32'(bus.state), 32'd0);
        check("seqC_pc", bus.pc, 32'h0);
        check("seqC_count", 32'(bus.instr_count), 32'd0);
        bus.run = 1'b0;
        tick();
        nreset = 1'b1;
        tick();
        check("seqC_idle_run0", 32'(bus.state), 32'd0);
        bus.run = 1'b1;
        tick();
        check("seqC_fetch", 32'(bus.ifetch_en), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_cycle_ctrl.md
CPU_CYCLE_CTRL -- requirements
Module: cpu_cycle_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 16, max cycles MEM waits for mem_ack.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 nreset  input  1  asynchronous, active-low reset.
REQ-005 run  input  1  1 = sequence instructions; 0 = stop at next instruction boundary.
REQ-006 exec_ok  input  1  condition-field pass for current instruction.
REQ-007 is_branch, is_link, is_mem, is_load, no_wb, wr_pc  input  1 each  decoded class: branch, branch-with-link, load/store, load, no register writeback (compare), Rd==15.
REQ-008 br_target  input  32  branch destination.
REQ-009 wb_data  input  32  writeback value (ALU or memory result).
REQ-010 mem_ack  input  1  memory completes the access.
REQ-011 pc  output  32  current program counter.
REQ-012 ifetch_en, rf_read_en, alu_en, mem_req, rf_write_en, link_we  output  1 each  datapath step enables.
REQ-013 state  output  3  FSM state, for debug port.
REQ-014 instr_count  output  16  retired-instruction counter.
REQ-015 err  output  1  sticky memory-timeout flag.

Function
REQ-016 States SHALL be IDLE=0, FETCH=1, READ=2, EXEC=3, MEM=4, WB=5; codes 6-7 SHALL go to IDLE next cycle.
REQ-017 Enables SHALL decode combinationally from state and decode inputs: ifetch_en in FETCH, rf_read_en in READ, alu_en in EXEC, mem_req in MEM, rf_write_en/link_we per REQ-023/REQ-021; all others 0.
REQ-018 IDLE -> FETCH when run=1 and err=0; otherwise stay in IDLE.
REQ-019 FETCH -> READ unconditionally, after 1 cycle.
REQ-020 READ: exec_ok=0 -> pc<=pc+4, no retire, "next" transition (REQ-025); exec_ok=1 -> EXEC.
REQ-021 EXEC with is_branch=1: pc<=br_target, link_we=1 for that cycle iff is_link, retire, "next" transition.
REQ-022 EXEC with is_mem=1 -> MEM; other instructions -> WB.
REQ-023 WB: no_wb=1 -> no write, pc<=pc+4; wr_pc=1 -> rf_write_en=0, pc<=wb_data; otherwise rf_write_en=1 for exactly one cycle, pc<=pc+4; all cases retire, "next" transition.
REQ-024 MEM: mem_req held high until mem_ack; on mem_ack, is_load -> WB, else (store) pc<=pc+4, retire, "next" transition.
REQ-025 "Next" transition SHALL be FETCH if run=1, IDLE if run=0.
REQ-026 run deasserting mid-instruction SHALL NOT abort it; it completes, then enters IDLE.
REQ-027 MEM wait counter SHALL reset on MEM entry; if MEM_TIMEOUT cycles elapse with mem_ack=0, then err<=1, state<=IDLE, pc unchanged, no retire.
REQ-028 mem_ack on the final allowed cycle SHALL complete normally (ack wins over timeout).
REQ-029 err SHALL be cleared only by reset; while err=1 the FSM stays in IDLE.
REQ-030 pc arithmetic SHALL be modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-031 instr_count SHALL increment by 1 per retire and wrap 16'hFFFF -> 0; skipped (exec_ok=0) instructions do not count.
REQ-032 Decode inputs SHALL be sampled only in READ..WB; mem_ack outside MEM SHALL be ignored.
REQ-033 Throughput: ALU op 4 cycles, branch 3, skipped 2, load 5+wait, store 4+wait.

Reset
REQ-034 nreset=0 SHALL immediately force state=IDLE, pc=RESET_PC, instr_count=0, err=0, all enables 0, wait counter 0, including mid-MEM (mem_req drops without waiting for ack).
REQ-035 After nreset rises, first FETCH SHALL occur one cycle after run=1 is sampled.

Verification
REQ-036 Reset, run=1, 3 ALU ops (exec_ok=1) -> pc 0,4,8,12; rf_write_en one pulse per op in WB; instr_count=3 after 12 cycles.
REQ-037 Branch, is_link=1, br_target=32'h40 -> link_we pulse in EXEC; next ifetch_en with pc=32'h40; instr_count+1.
REQ-038 exec_ok=0 in READ -> no alu_en/rf_write_en; pc+4; instr_count unchanged; FETCH 2 cycles after prior FETCH.
REQ-039 Load with mem_ack after 3 wait cycles -> mem_req high 3 cycles, then WB with rf_write_en=1; wr_pc=1 variant loads pc=wb_data.
REQ-040 Store with no mem_ack -> err=1 after 16 MEM cycles, state=IDLE, pc held; run=1 stays IDLE until nreset pulse clears err.
REQ-041 nreset pulsed low mid-MEM, and run dropped during EXEC -> immediate reset values; instruction completes then IDLE respectively.
